// File: rtl/tic_move_gen_if.sv
// Board/strobe bundle between the tic-tac-toe game controller and the
// automated move generator.
//   master : game side. Drives start, pos1..pos9 and who. Receives computer_position, pc, busy and no_move.
//   slave  : move generator. Directions are the reverse of master.
// Cell codes: 00 empty, 01 player, 10 computer, 11 occupied.
interface tic_move_gen_if;
  logic       start;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] who;
  logic [3:0] computer_position;
  logic       pc;
  logic       busy;
  logic       no_move;

  modport master (
    output start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
    input  computer_position, pc, busy, no_move
  );

  modport slave (
    input  start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
    output computer_position, pc, busy, no_move
  );
endinterface

// File: rtl/tic_move_gen.sv
// Automated computer player for the tic-tac-toe controller.
//
// When start is accepted, the generator snapshots the board and the winner code.
// It then scans for a move in this order: win, block, preference list.
// It drives computer_position and a pc strobe that lasts HOLD_CYCLES cycles.
//
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : tic_move_gen_if.slave (start, pos1..pos9, who in; computer_position, pc, busy, no_move out)
// Parameter:
//   HOLD_CYCLES : number of cycles pc stays high (1..15)
// Build option:
//   TIC_MOVE_GEN_BLOCK_EN : when defined, a BLOCK scan runs between WIN and PREF.
//
// state  | meaning
// IDLE   | waiting for start
// SNAP   | capture board; a decided game goes to NOMOVE
// WIN    | one line per cycle, looking for two computer cells plus one empty cell
// BLOCK  | one line per cycle, looking for two player cells plus one empty cell (build option)
// PREF   | one candidate per cycle from the list 4,0,2,6,8,1,3,5,7
// ISSUE  | pc high with computer_position held
// NOMOVE | one-cycle no_move pulse
module tic_move_gen #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic           clock,
  input  logic           reset,
  tic_move_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, SNAP, WIN,
`ifdef TIC_MOVE_GEN_BLOCK_EN
    BLOCK,
`endif
    PREF, ISSUE, NOMOVE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cell_q  [0:8];
  logic [1:0] cell_in [0:8];
  logic [2:0] line_q, line_d;
  logic [3:0] pref_q, pref_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] pos_q, pos_d;
  logic       snap_en;

  logic [11:0] lc;
  logic [3:0]  idx_a, idx_b, idx_c;
  logic [1:0]  ca, cb, cc, target;
  logic        line_hit;
  logic [3:0]  line_empty;
  logic [3:0]  pref_idx;

  assign cell_in = '{bus.pos1, bus.pos2, bus.pos3, bus.pos4, bus.pos5,
                     bus.pos6, bus.pos7, bus.pos8, bus.pos9};

  // Three cell indices of line k, packed as {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [2:0] k);
    case (k)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  function automatic logic [3:0] pref_cell(input logic [3:0] i);
    case (i)
      4'd0:    return 4'd4;
      4'd1:    return 4'd0;
      4'd2:    return 4'd2;
      4'd3:    return 4'd6;
      4'd4:    return 4'd8;
      4'd5:    return 4'd1;
      4'd6:    return 4'd3;
      4'd7:    return 4'd5;
      default: return 4'd7;
    endcase
  endfunction

  // Line evaluator shared by WIN and BLOCK. Only the target code differs.
  // Code 11 never equals the target and is never empty, so it can never produce a hit.
  always_comb begin
    lc         = line_cells(line_q);
    idx_a      = lc[11:8];
    idx_b      = lc[7:4];
    idx_c      = lc[3:0];
    ca         = cell_q[idx_a];
    cb         = cell_q[idx_b];
    cc         = cell_q[idx_c];
`ifdef TIC_MOVE_GEN_BLOCK_EN
    target     = (state_q == BLOCK) ? 2'b01 : 2'b10;
`else
    target     = 2'b10;
`endif
    line_hit   = 1'b0;
    line_empty = idx_c;
    if (ca == target && cb == target && cc == 2'b00) begin
      line_hit   = 1'b1;
      line_empty = idx_c;
    end else if (ca == target && cc == target && cb == 2'b00) begin
      line_hit   = 1'b1;
      line_empty = idx_b;
    end else if (cb == target && cc == target && ca == 2'b00) begin
      line_hit   = 1'b1;
      line_empty = idx_a;
    end
  end

  assign pref_idx = pref_cell(pref_q);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    pref_d  = pref_q;
    hold_d  = hold_q;
    pos_d   = pos_q;
    snap_en = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = SNAP;
      SNAP: begin
        // The live who input equals the value being captured at this edge.
        // Nothing reads it again later, so it is decided here and not stored.
        snap_en = 1'b1;
        if (bus.who != 2'b00) begin
          state_d = NOMOVE;
        end else begin
          state_d = WIN;
          line_d  = '0;
        end
      end
      WIN: begin
        if (line_hit) begin
          pos_d   = line_empty;
          hold_d  = HOLD_LAST;
          state_d = ISSUE;
        end else if (line_q == 3'd7) begin
`ifdef TIC_MOVE_GEN_BLOCK_EN
          line_d  = '0;
          state_d = BLOCK;
`else
          pref_d  = '0;
          state_d = PREF;
`endif
        end else begin
          line_d = line_q + 3'd1;
        end
      end
`ifdef TIC_MOVE_GEN_BLOCK_EN
      BLOCK: begin
        if (line_hit) begin
          pos_d   = line_empty;
          hold_d  = HOLD_LAST;
          state_d = ISSUE;
        end else if (line_q == 3'd7) begin
          pref_d  = '0;
          state_d = PREF;
        end else begin
          line_d = line_q + 3'd1;
        end
      end
`endif
      PREF: begin
        if (cell_q[pref_idx] == 2'b00) begin
          pos_d   = pref_idx;
          hold_d  = HOLD_LAST;
          state_d = ISSUE;
        end else if (pref_q == 4'd8) begin
          state_d = NOMOVE;
        end else begin
          pref_d = pref_q + 4'd1;
        end
      end
      ISSUE: begin
        if (hold_q == 4'd0) state_d = IDLE;
        else                hold_d  = hold_q - 4'd1;
      end
      NOMOVE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      pref_q  <= '0;
      hold_q  <= '0;
      pos_q   <= '0;
      cell_q  <= '{default: 2'b00};
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      pref_q  <= pref_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
      if (snap_en) cell_q <= cell_in;
    end
  end

  assign bus.computer_position = pos_q;
  assign bus.pc                = (state_q == ISSUE);
  assign bus.busy              = (state_q != IDLE);
  assign bus.no_move           = (state_q == NOMOVE);

endmodule

// File: tb/tb_tic_move_gen.sv
// Bench for tic_move_gen. Two instances share the stimulus: one with HOLD_CYCLES=1 and one with HOLD_CYCLES=3.
// Expected cycles depend on TIC_MOVE_GEN_BLOCK_EN.
module tb_tic_move_gen;

`ifdef TIC_MOVE_GEN_BLOCK_EN
  localparam int PREF0 = 18;
  localparam bit BLK   = 1'b1;
`else
  localparam int PREF0 = 10;
  localparam bit BLK   = 1'b0;
`endif
  localparam int NCYC = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cells [0:8];
  logic [1:0] who   = 2'b00;

  always #5 clock = ~clock;

  tic_move_gen_if if_a ();
  tic_move_gen_if if_b ();

  assign if_a.start = start;  assign if_b.start = start;
  assign if_a.who   = who;    assign if_b.who   = who;
  assign if_a.pos1 = cells[0]; assign if_b.pos1 = cells[0];
  assign if_a.pos2 = cells[1]; assign if_b.pos2 = cells[1];
  assign if_a.pos3 = cells[2]; assign if_b.pos3 = cells[2];
  assign if_a.pos4 = cells[3]; assign if_b.pos4 = cells[3];
  assign if_a.pos5 = cells[4]; assign if_b.pos5 = cells[4];
  assign if_a.pos6 = cells[5]; assign if_b.pos6 = cells[5];
  assign if_a.pos7 = cells[6]; assign if_b.pos7 = cells[6];
  assign if_a.pos8 = cells[7]; assign if_b.pos8 = cells[7];
  assign if_a.pos9 = cells[8]; assign if_b.pos9 = cells[8];

  tic_move_gen #(.HOLD_CYCLES(1)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
  tic_move_gen #(.HOLD_CYCLES(3)) dut_b (.clock(clock), .reset(reset), .bus(if_b));

  typedef struct {
    string       name;
    logic [17:0] board;   // cell i at bits [2i+1:2i]
    logic [1:0]  who;
    int          pc_cyc;  // first pc cycle, 0 = never
    int          nm_cyc;  // no_move cycle, 0 = never
    int          pos;     // computer_position at end of run
  } vec_t;

  int nchk = 0;
  int nerr = 0;

  int pc_r   [0:1][0:NCYC];
  int busy_r [0:1][0:NCYC];
  int nm_r   [0:1][0:NCYC];
  int pos_r  [0:1][0:NCYC];

  function automatic logic [17:0] brd(input int c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {2'(c8), 2'(c7), 2'(c6), 2'(c5), 2'(c4), 2'(c3), 2'(c2), 2'(c1), 2'(c0)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Applies a board, pulses start and records 40 cycles of outputs.
  // At cycle 2 the inputs are scrambled to show that the snapshot is what counts.
  task automatic run(input vec_t v, input int rst_cyc, input int extra_cyc);
    for (int i = 0; i < 9; i++) cells[i] = v.board[2*i +: 2];
    who   = v.who;
    start = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clock);
      pc_r[0][c] = int'(if_a.pc);   busy_r[0][c] = int'(if_a.busy);
      nm_r[0][c] = int'(if_a.no_move); pos_r[0][c] = int'(if_a.computer_position);
      pc_r[1][c] = int'(if_b.pc);   busy_r[1][c] = int'(if_b.busy);
      nm_r[1][c] = int'(if_b.no_move); pos_r[1][c] = int'(if_b.computer_position);
      if (c == 1) start = 1'b0;
      if (c == 2) begin
        for (int i = 0; i < 9; i++) cells[i] = 2'b01;
        who = 2'b00;
      end
      if (c == extra_cyc) start = 1'b1;
      else if (c == extra_cyc + 1) start = 1'b0;
      if (c == rst_cyc) reset = 1'b1;
      else if (c == rst_cyc + 1) reset = 1'b0;
    end
  endtask

  task automatic analyze(input int k, output int pc_first, output int pc_cnt,
                         output int busy_last, output int busy_cnt,
                         output int nm_first, output int nm_cnt, output int pos_pc);
    pc_first = 0; pc_cnt = 0; busy_last = 0; busy_cnt = 0;
    nm_first = 0; nm_cnt = 0; pos_pc = -1;
    for (int c = 1; c <= NCYC; c++) begin
      if (pc_r[k][c] != 0) begin
        if (pc_cnt == 0) begin pc_first = c; pos_pc = pos_r[k][c]; end
        pc_cnt++;
      end
      if (busy_r[k][c] != 0) begin busy_last = c; busy_cnt++; end
      if (nm_r[k][c] != 0) begin
        if (nm_cnt == 0) nm_first = c;
        nm_cnt++;
      end
    end
  endtask

  task automatic check_vec(input vec_t v);
    int pf, pn, bl, bn, nf, nn, pp, last;
    for (int k = 0; k < 2; k++) begin
      int hold;
      hold = (k == 0) ? 1 : 3;
      analyze(k, pf, pn, bl, bn, nf, nn, pp);
      last = (v.pc_cyc != 0) ? v.pc_cyc + hold - 1 : v.nm_cyc;
      chk($sformatf("%s[%0d] pc_count", v.name, k), pn, (v.pc_cyc != 0) ? hold : 0);
      chk($sformatf("%s[%0d] pc_first", v.name, k), pf, v.pc_cyc);
      chk($sformatf("%s[%0d] no_move_cycle", v.name, k), nf, v.nm_cyc);
      chk($sformatf("%s[%0d] no_move_count", v.name, k), nn, (v.nm_cyc != 0) ? 1 : 0);
      chk($sformatf("%s[%0d] busy_last", v.name, k), bl, last);
      chk($sformatf("%s[%0d] busy_count", v.name, k), bn, last);
      chk($sformatf("%s[%0d] pos_end", v.name, k), pos_r[k][NCYC], v.pos);
      if (v.pc_cyc != 0) begin
        chk($sformatf("%s[%0d] pos_at_pc", v.name, k), pp, v.pos);
        chk($sformatf("%s[%0d] pos_at_pc_end", v.name, k), pos_r[k][v.pc_cyc + hold - 1], v.pos);
      end
    end
  endtask

  vec_t vecs [0:10];

  initial begin
    int pf, pn, bl, bn, nf, nn, pp;
    vec_t ve;
    for (int i = 0; i < 9; i++) cells[i] = 2'b00;

    vecs[0]  = '{"empty",     brd(0,0,0,0,0,0,0,0,0), 2'b00, PREF0 + 1, 0, 4};
    vecs[1]  = '{"win_l0",    brd(2,2,0,1,1,0,0,0,0), 2'b00, 3,         0, 2};
    vecs[2]  = '{"occ11",     brd(2,2,3,1,1,3,0,0,0), 2'b00, PREF0 + 4, 0, 6};
    vecs[3]  = '{"block_l6",  brd(1,2,0,0,1,0,0,0,0), 2'b00, BLK ? 17 : 13, 0, BLK ? 8 : 2};
    vecs[4]  = '{"who_player", brd(0,0,0,0,0,0,0,0,0), 2'b01, 0, 2, BLK ? 8 : 2};
    vecs[5]  = '{"full",      brd(1,2,1,2,3,2,1,2,3), 2'b00, 0, PREF0 + 9, BLK ? 8 : 2};
    vecs[6]  = '{"last_pref", brd(1,2,1,2,3,2,1,0,3), 2'b00, PREF0 + 9, 0, 7};
    vecs[7]  = '{"win_l7",    brd(0,0,2,0,2,0,0,0,0), 2'b00, 10,        0, 6};
    vecs[8]  = '{"win_prio",  brd(1,1,0,0,0,0,2,2,0), 2'b00, 5,         0, 8};
    vecs[9]  = '{"draw",      brd(0,0,0,0,0,0,0,0,0), 2'b11, 0, 2, 8};
    vecs[10] = '{"who_comp",  brd(2,2,0,1,1,0,0,0,0), 2'b10, 0, 2, 8};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset busy_a", int'(if_a.busy), 0);
    chk("reset pc_a", int'(if_a.pc), 0);
    chk("reset no_move_a", int'(if_a.no_move), 0);
    chk("reset pos_a", int'(if_a.computer_position), 0);
    chk("reset busy_b", int'(if_b.busy), 0);
    chk("reset pc_b", int'(if_b.pc), 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i <= 10; i++) begin
      run(vecs[i], 0, 0);
      check_vec(vecs[i]);
    end

    // Reset during the scan: reset is sampled at edge 5, so outputs are at reset values from cycle 6.
    run(vecs[0], 5, 0);
    for (int k = 0; k < 2; k++) begin
      analyze(k, pf, pn, bl, bn, nf, nn, pp);
      chk($sformatf("rst[%0d] busy_c5", k), busy_r[k][5], 1);
      chk($sformatf("rst[%0d] busy_c6", k), busy_r[k][6], 0);
      chk($sformatf("rst[%0d] pos_c6", k), pos_r[k][6], 0);
      chk($sformatf("rst[%0d] pc_count", k), pn, 0);
      chk($sformatf("rst[%0d] no_move_count", k), nn, 0);
      chk($sformatf("rst[%0d] busy_last", k), bl, 5);
    end

    // Fresh start on an empty board, with a second start at cycle 5 that must be ignored.
    ve = vecs[0];
    ve.name = "restart";
    run(ve, 0, 5);
    check_vec(ve);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
